mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 51 +++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response/data-memory bundle for mem_access_unit.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes; dmem_good stalls the access.
interface mem_access_unit_if;
  // pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [4:0]  req_rd;
  // pipeline response
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  // data-memory port
  logic        dmem_valid;
  logic        dmem_memRead;
  logic        dmem_memWrite;
  logic        dmem_sext;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_writeData;
  logic [1:0]  dmem_maskMode;
  logic        dmem_good;
  logic [31:0] dmem_readData;

  // unit side
  modport slave (
    input  req_valid, req_load, req_store, req_addr, req_wdata, req_size, req_sext, req_rd,
    output req_ready,
    output resp_valid, resp_data, resp_rd, resp_err,
    input  resp_ready,
    output dmem_valid, dmem_memRead, dmem_memWrite, dmem_sext, dmem_addr, dmem_writeData, dmem_maskMode,
    input  dmem_good, dmem_readData
  );

  // pipeline + memory side
  modport master (
    output req_valid, req_load, req_store, req_addr, req_wdata, req_size, req_sext, req_rd,
    input  req_ready,
    input  resp_valid, resp_data, resp_rd, resp_err,
    output resp_ready,
    input  dmem_valid, dmem_memRead, dmem_memWrite, dmem_sext, dmem_addr, dmem_writeData, dmem_maskMode,
    output dmem_good, dmem_readData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between pipeline and data memory; optional LSU_MISALIGN_TRAP_EN.
// Latency: accept N, ACCESS N+1, response N+2 when memory is good at once; illegal requests respond at N+1.
// Backpressure: req_ready only in IDLE; response held until resp_ready; ACCESS waits up to TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, resp_data_q;
  logic [1:0]  size_q;
  logic        sext_q, load_q, store_q, resp_err_q;
  logic [4:0]  rd_q;
  logic [7:0]  cnt_q;
  logic        misalign, illegal, cnt_done;
  logic [31:0] access_addr;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                    (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A request that must never touch memory: bad op encoding, bad size, or trapped misalignment.
  assign illegal  = (bus.req_load == bus.req_store) || (bus.req_size == 2'b11) || misalign;
  assign cnt_done = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Address presented to memory; without the trap, low bits are silently dropped to the access size.
  always_comb begin
    access_addr = addr_q;
`ifndef LSU_MISALIGN_TRAP_EN
    case (size_q)
      2'b01:   access_addr = {addr_q[31:1], 1'b0};
      2'b10:   access_addr = {addr_q[31:2], 2'b00};
      default: access_addr = addr_q;
    endcase
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake/memory outputs; reset gates the access strobes so an aborted store cannot commit.
  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.dmem_valid     = 1'b0;
    bus.dmem_memRead   = 1'b0;
    bus.dmem_memWrite  = 1'b0;
    bus.dmem_sext      = 1'b0;
    bus.dmem_addr      = 32'h0;
    bus.dmem_writeData = 32'h0;
    bus.dmem_maskMode  = 2'b00;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.dmem_valid     = ~reset;
        bus.dmem_memRead   = load_q & ~reset;
        bus.dmem_memWrite  = store_q & ~reset;
        bus.dmem_sext      = sext_q;
        bus.dmem_addr      = access_addr;
        bus.dmem_writeData = wdata_q;
        bus.dmem_maskMode  = size_q;
        if (bus.dmem_good || cnt_done) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      rd_q        <= 5'h0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      cnt_q       <= 8'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            size_q      <= bus.req_size;
            sext_q      <= bus.req_sext;
            rd_q        <= bus.req_rd;
            load_q      <= bus.req_load;
            store_q     <= bus.req_store;
            cnt_q       <= 8'h0;
            resp_data_q <= 32'h0;
            resp_err_q  <= illegal;
          end
        end
        ACCESS: begin
          if (bus.dmem_good) begin
            resp_data_q <= load_q ? bus.dmem_readData : 32'h0;
            resp_err_q  <= 1'b0;
          end else if (cnt_done) begin
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_rd   = rd_q;
  assign bus.resp_err  = resp_err_q;

endmodule
